bcd_time_counter: RTL

Time-of-day counter that produces the nine BCD digits (hours, minutes, seconds, milliseconds) consumed by the segment-pattern decoder directly downstream. It derives a 1 ms tick from the system clock with an internal prescaler. Each tick advances a 24-hour HH:MM:SS.mmm count with full BCD carry propagation. The count supports run/pause, synchronous clear, and validated preset load.

---
 rtl/bcd_time_pkg.sv | 26 ++
 rtl/bcd_digit_counter.sv | 44 ++++
 rtl/bcd_time_counter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bcd_time_pkg.sv
// bcd_time_pkg: shared types, digit limits and the preset validity check
// for the bcd_time_counter slice.
package bcd_time_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MS_DIGIT_MAX        = 4'd9;
    localparam bcd_t MS_TENS_MAX         = 4'd5;
    localparam bcd_t HOURS_MAX_TENS      = 4'd2;
    localparam bcd_t HOURS_MAX_ONES_AT_2 = 4'd3;

    // True when the preset is a legal 24-hour HH:MM:SS value.
    function automatic logic bcd_time_valid(
        input bcd_t h1, input bcd_t h0,
        input bcd_t m1, input bcd_t m0,
        input bcd_t s1, input bcd_t s0
    );
        logic ok;
        ok = (h0 <= MS_DIGIT_MAX) && (m0 <= MS_DIGIT_MAX) && (s0 <= MS_DIGIT_MAX) &&
             (m1 <= MS_TENS_MAX) && (s1 <= MS_TENS_MAX) &&
             ((h1 < HOURS_MAX_TENS) ||
              ((h1 == HOURS_MAX_TENS) && (h0 <= HOURS_MAX_ONES_AT_2)));
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit counting 0..MAX_VAL.
//   clk, rst_n   clock / async active-low reset
//   zero         synchronous clear to 0 (highest priority)
//   load         synchronous load of load_val
//   en           carry-in; advances the digit by one
//   digit        registered digit value
//   carry_out    en while the digit sits at MAX_VAL (combinational, for the chain)
module bcd_digit_counter
    import bcd_time_pkg::*;
#(
    parameter bcd_t MAX_VAL = MS_DIGIT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic zero,
    input  logic load,
    input  bcd_t load_val,
    input  logic en,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (zero) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = load_val;
        end else if (en) begin
            digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) digit_q <= '0;
        else        digit_q <= digit_d;
    end

    assign digit     = digit_q;
    assign carry_out = en && (digit_q == MAX_VAL);

endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour HH:MM:SS.mmm BCD time-of-day counter advanced by
// an internal CLK_HZ/TICK_HZ prescaler.
//   run            level enable for prescaler and count
//   clear          zeroes time and prescaler (beats load and increment)
//   load, load_*   validated HH:MM:SS preset; ms and prescaler zeroed on accept
//   hours*..milliseconds*  registered BCD digits
//   tick           pulse per counted increment
//   day_wrap       pulse on 23:59:59.999 -> 00:00:00.000
//   load_err       pulse when a preset is rejected
//   lap_hold       only with BCD_TIME_LAP_EN: freezes displayed digits
// Optional feature macro: BCD_TIME_LAP_EN.
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_hours1,
    input  logic [3:0] load_hours0,
    input  logic [3:0] load_minutes1,
    input  logic [3:0] load_minutes0,
    input  logic [3:0] load_seconds1,
    input  logic [3:0] load_seconds0,
`ifdef BCD_TIME_LAP_EN
    input  logic       lap_hold,
`endif
    output logic [3:0] hours1,
    output logic [3:0] hours0,
    output logic [3:0] minutes1,
    output logic [3:0] minutes0,
    output logic [3:0] seconds1,
    output logic [3:0] seconds0,
    output logic [3:0] milliseconds2,
    output logic [3:0] milliseconds1,
    output logic [3:0] milliseconds0,
    output logic       tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          load_ok, load_acc, inc, hour_en, hour_at_max;
    logic          c_ms0, c_ms1, c_ms2, c_s0, c_s1, c_m0, c_m1;
    bcd_t          ms0, ms1, ms2, s0, s1, m0, m1;
    bcd_t          h1_q, h1_d, h0_q, h0_d;
    logic          tick_q, day_wrap_q, load_err_q;

    assign load_ok  = bcd_time_valid(load_hours1, load_hours0, load_minutes1,
                                     load_minutes0, load_seconds1, load_seconds0);
    assign load_acc = load && !clear && load_ok;
    // Any clear or load cycle swallows a coincident increment.
    assign inc      = run && !clear && !load && (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q;
        if (clear || load_acc) begin
            presc_d = '0;
        end else if (run && !load) begin
            presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
        end
    end

    bcd_digit_counter #(.MAX_VAL(MS_DIGIT_MAX)) u_ms0 (
        .clk(clk), .rst_n(rst_n), .zero(clear || load_acc), .load(1'b0), .load_val('0),
        .en(inc), .digit(ms0), .carry_out(c_ms0));
    bcd_digit_counter #(.MAX_VAL(MS_DIGIT_MAX)) u_ms1 (
        .clk(clk), .rst_n(rst_n), .zero(clear || load_acc), .load(1'b0), .load_val('0),
        .en(c_ms0), .digit(ms1), .carry_out(c_ms1));
    bcd_digit_counter #(.MAX_VAL(MS_DIGIT_MAX)) u_ms2 (
        .clk(clk), .rst_n(rst_n), .zero(clear || load_acc), .load(1'b0), .load_val('0),
        .en(c_ms1), .digit(ms2), .carry_out(c_ms2));
    bcd_digit_counter #(.MAX_VAL(MS_DIGIT_MAX)) u_s0 (
        .clk(clk), .rst_n(rst_n), .zero(clear), .load(load_acc), .load_val(load_seconds0),
        .en(c_ms2), .digit(s0), .carry_out(c_s0));
    bcd_digit_counter #(.MAX_VAL(MS_TENS_MAX)) u_s1 (
        .clk(clk), .rst_n(rst_n), .zero(clear), .load(load_acc), .load_val(load_seconds1),
        .en(c_s0), .digit(s1), .carry_out(c_s1));
    bcd_digit_counter #(.MAX_VAL(MS_DIGIT_MAX)) u_m0 (
        .clk(clk), .rst_n(rst_n), .zero(clear), .load(load_acc), .load_val(load_minutes0),
        .en(c_s1), .digit(m0), .carry_out(c_m0));
    bcd_digit_counter #(.MAX_VAL(MS_TENS_MAX)) u_m1 (
        .clk(clk), .rst_n(rst_n), .zero(clear), .load(load_acc), .load_val(load_minutes1),
        .en(c_m0), .digit(m1), .carry_out(c_m1));

    assign hour_en     = c_m1;
    assign hour_at_max = (h1_q == HOURS_MAX_TENS) && (h0_q == HOURS_MAX_ONES_AT_2);

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        if (clear) begin
            h1_d = '0;
            h0_d = '0;
        end else if (load_acc) begin
            h1_d = load_hours1;
            h0_d = load_hours0;
        end else if (hour_en) begin
            if (hour_at_max) begin
                h1_d = '0;
                h0_d = '0;
            end else if (h0_q == MS_DIGIT_MAX) begin
                h1_d = h1_q + 4'd1;
                h0_d = '0;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            h1_q       <= '0;
            h0_q       <= '0;
            tick_q     <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            h1_q       <= h1_d;
            h0_q       <= h0_d;
            tick_q     <= inc;
            day_wrap_q <= hour_en && hour_at_max;
            load_err_q <= load && !clear && !load_ok;
        end
    end

    assign tick     = tick_q;
    assign day_wrap = day_wrap_q;
    assign load_err = load_err_q;

    logic [35:0] live;
    assign live = {h1_q, h0_q, m1, m0, s1, s0, ms2, ms1, ms0};

`ifdef BCD_TIME_LAP_EN
    // shadow_q keeps following the live count until the first held cycle has
    // been registered in lap_q, so it captures the value shown when lap_hold rose.
    logic [35:0] shadow_q;
    logic        lap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            lap_q    <= 1'b0;
        end else begin
            shadow_q <= lap_q ? shadow_q : live;
            lap_q    <= lap_hold;
        end
    end

    assign {hours1, hours0, minutes1, minutes0, seconds1, seconds0,
            milliseconds2, milliseconds1, milliseconds0} = lap_q ? shadow_q : live;
`else
    assign {hours1, hours0, minutes1, minutes0, seconds1, seconds0,
            milliseconds2, milliseconds1, milliseconds0} = live;
`endif

endmodule
